// File: rtl/mem_banked_spram.sv
// mem_banked_spram: banked, word-addressed on-chip RAM slave for the shared
// CPU memory bus. Decodes its own address window and tracks one request at a
// time through an IDLE/WAIT/DONE handshake FSM.
//
// Optional feature macro: MEM_BANKED_ERR_EN (enables the err flag and write
// suppression for flagged accesses; when undefined err is tied to 0).
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   addr    byte address (bits [1:0] ignored for data access)
//   wdata   write data
//   wmask   byte-lane write enables
//   wen     write request level
//   ren     read request level
//   rdata   read data, valid while done=1 for a read
//   done    transaction complete (combinational on live request)
//   active  addr lies inside this slave's window (combinational)
//   err     out-of-range / misaligned flag (MEM_BANKED_ERR_EN only)
module mem_banked_spram #(
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned WORDS_PER_BANK = 16384,
  parameter logic [31:0] BASE_ADDR      = 32'hf0000000,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        done,
  output logic        active,
  output logic        err
);

  localparam int unsigned ROW_W   = $clog2(WORDS_PER_BANK);
  localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned SIZE    = NUM_BANKS * WORDS_PER_BANK * 4;
  localparam logic [32:0] WIN_END = 33'(BASE_ADDR) + 33'(SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

  state_t      state, state_n;
  op_t         op_q;
  logic [31:0] xact_addr;
  logic [31:0] rd_q;

  logic              accept_c;
  logic              match_c;
  logic              wr_ok_c;
  logic              wr_en_c;
  logic [ROW_W-1:0]  row_c;
  logic [BANK_W-1:0] bank_c;
  logic [31:0]       rd_word_c;
  logic [31:0]       bank_rd [NUM_BANKS];

  // Window decode; 33-bit compare so a window ending at 4 GiB cannot wrap.
  assign active = (addr >= BASE_ADDR) && ({1'b0, addr} < WIN_END);

  // BASE_ADDR is aligned to the window size, so the low address bits equal
  // the window-local offset and no subtraction is needed.
  assign row_c  = addr[2 +: ROW_W];
  assign bank_c = addr[2 + ROW_W +: BANK_W];

  assign accept_c = rst_n && (state == ST_IDLE) && active && (ren || wen);
  assign match_c  = (ren || wen) && (addr == xact_addr) && active;
  assign done     = (state == ST_DONE) && match_c;
  assign wr_en_c  = accept_c && wen && wr_ok_c;

  // One array per bank; only the addressed bank sees a write enable.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [31:0] mem [WORDS_PER_BANK];

    always_ff @(posedge clk) begin
      if (wr_en_c && (bank_c == BANK_W'(b))) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) mem[row_c][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end

    assign bank_rd[b] = mem[row_c];
  end

  assign rd_word_c = bank_rd[bank_c];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_n = (!wen && (READ_LATENCY == 2)) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: state_n = (op_q == OP_READ) ? ST_DONE : ST_IDLE;
      ST_DONE: if (!match_c) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Transaction latch and read data path; ren&&wen is a write and leaves rdata alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xact_addr <= 32'd0;
      op_q      <= OP_NONE;
      rd_q      <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      if (accept_c) begin
        xact_addr <= addr;
        op_q      <= wen ? OP_WRITE : OP_READ;
        if (!wen) begin
          if (READ_LATENCY == 1) rdata <= rd_word_c;
          else                   rd_q  <= rd_word_c;
        end
      end
      if (state == ST_WAIT) rdata <= rd_q;
    end
  end

`ifdef MEM_BANKED_ERR_EN
  logic err_src_c;
  logic err_q;
  logic err_pend;

  assign err_src_c = active &&
                     (((addr[1:0] != 2'b00) && (wmask != 4'hf) && (wmask != 4'h0)) ||
                      (32'(bank_c) >= NUM_BANKS));
  assign wr_ok_c   = !err_src_c;
  assign err       = err_q;

  // err rises together with entry to DONE and clears when the transaction ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      err_pend <= 1'b0;
    end else if (accept_c) begin
      if (state_n == ST_WAIT) err_pend <= err_src_c;
      else                    err_q    <= err_src_c;
    end else if (state == ST_WAIT) begin
      err_q <= err_pend;
    end else if ((state == ST_DONE) && (state_n == ST_IDLE)) begin
      err_q <= 1'b0;
    end
  end
`else
  assign wr_ok_c = 1'b1;
  assign err     = 1'b0;
`endif

endmodule
